// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage, carry rippled stage to stage.
// Optional macro PIPE_ADDER_SAT_EN saturates the result in the last stage (no extra latency).
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_sat
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("pipe_adder: WIDTH must be a multiple of CHUNK");
    end

    // Slot k holds a beat whose slices below k are done and whose carry into slice k is cy_q[k].
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  a_d  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  b_d  [STAGES];
    logic [WIDTH-1:0]  ps_q [STAGES];
    logic [WIDTH-1:0]  ps_d [STAGES];

    logic [CHUNK:0]    slice_res [STAGES];
    logic [WIDTH-1:0]  ps_next   [STAGES];

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_sum_q, out_sum_d;
    logic              out_cout_q, out_cout_d;
`ifdef PIPE_ADDER_SAT_EN
    logic [STAGES-1:0] sub_q, sub_d;
    logic              out_sat_q, out_sat_d;
`endif

    logic advance;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin : slice_add
        for (int k = 0; k < STAGES; k++) begin
            slice_res[k] = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
                         + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, cy_q[k]};
            ps_next[k]   = ps_q[k];
            ps_next[k][k*CHUNK +: CHUNK] = slice_res[k][CHUNK-1:0];
        end
    end

    always_comb begin : next_state
        // NOTE: every _d defaults to its _q, so a stall holds state and no latch can be inferred.
        vld_d       = vld_q;
        cy_d        = cy_q;
        a_d         = a_q;
        b_d         = b_q;
        ps_d        = ps_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
`ifdef PIPE_ADDER_SAT_EN
        sub_d       = sub_q;
        out_sat_d   = out_sat_q;
`endif
        if (advance) begin
            // Subtract is A + ~B + 1, so the operand is inverted and carry forced on entry.
            vld_d[0] = in_valid;
            cy_d[0]  = in_sub | in_cin;
            a_d[0]   = in_a;
            b_d[0]   = in_sub ? ~in_b : in_b;
            ps_d[0]  = '0;
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                cy_d[k]  = slice_res[k-1][CHUNK];
                a_d[k]   = a_q[k-1];
                b_d[k]   = b_q[k-1];
                ps_d[k]  = ps_next[k-1];
            end
            out_valid_d = vld_q[LAST];
            out_sum_d   = ps_next[LAST];
            out_cout_d  = slice_res[LAST][CHUNK];
`ifdef PIPE_ADDER_SAT_EN
            sub_d[0] = in_sub;
            for (int k = 1; k < STAGES; k++) begin
                sub_d[k] = sub_q[k-1];
            end
            out_sat_d = 1'b0;
            if (!sub_q[LAST] && slice_res[LAST][CHUNK]) begin
                out_sum_d = '1;
                out_sat_d = 1'b1;
            end else if (sub_q[LAST] && !slice_res[LAST][CHUNK]) begin
                out_sum_d = '0;
                out_sat_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the slot arrays are plain flops rather than RAM, so they clear along with everything else.
            vld_q       <= '0;
            cy_q        <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                ps_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
`ifdef PIPE_ADDER_SAT_EN
            sub_q       <= '0;
            out_sat_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking, so each slot loads its neighbour's pre-edge value.
            vld_q       <= vld_d;
            cy_q        <= cy_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ps_q        <= ps_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
`ifdef PIPE_ADDER_SAT_EN
            sub_q       <= sub_d;
            out_sat_q   <= out_sat_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
`ifdef PIPE_ADDER_SAT_EN
    assign out_sat   = out_sat_q;
`else
    assign out_sat   = 1'b0;
`endif

endmodule
